// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, state encoding, Rcon table and the S-box.
// The S-box function is shared with the encrypt round's SubBytes stage.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Round constant for round idx (1..10); index 0 and out-of-range give 0.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Pure table lookup through the shared package function.
    always_comb dout = sbox(din);

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per rk_valid/rk_ready handshake,
// round 0 (cipher key) through round 10, then a one-cycle done pulse.
// Optional macro ROUND_KEY_STORE_EN adds an 11-entry round-key file with a
// registered read port (rd_idx/rd_key) for reverse-order key supply.
module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             ready,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_index,
`ifdef ROUND_KEY_STORE_EN
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key,
`endif
    output logic             done
);

    state_t           state, state_nxt;
    logic [3:0]       round;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] next_key;
    logic             done_r;
    logic             hs;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = cur_key;
    assign rot = {w3[23:0], w3[31:24]};

    // SubWord: four byte-wide S-boxes on the rotated last word.
    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .din  (rot[8*g +: 8]),
            .dout (sub[8*g +: 8])
        );
    end

    // Next round key, combinational from cur_key; only registered on a handshake.
    always_comb begin
        n0       = w0 ^ sub ^ {rcon(round + 4'd1), 24'h0};
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    assign hs       = rk_valid & rk_ready;
    assign ready    = (state == IDLE);
    assign rk_valid = (state == EMIT);
    assign rk_out   = cur_key;
    assign rk_index = round;
    assign done     = done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE -> EMIT on start, EMIT -> IDLE after the last key is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EMIT;
            EMIT:    if (hs && round == LAST_ROUND) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Key/round datapath and done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_key <= '0;
            round   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= hs && (round == LAST_ROUND);
            if (state == IDLE) begin
                if (start) begin
                    cur_key <= key_in;
                    round   <= '0;
                end
            end else if (hs && round != LAST_ROUND) begin
                cur_key <= next_key;
                round   <= round + 4'd1;
            end
        end
    end

`ifdef ROUND_KEY_STORE_EN
    logic [KEY_W-1:0] rf [0:NR];

    // Round-key file: captures each key as it is handed off; reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= NR; i++) rf[i] <= '0;
        end else if (hs) begin
            rf[round] <= cur_key;
        end
    end

    // Registered read port; indices beyond round 10 read as zero.
    always_ff @(posedge clk) begin
        if (!reset)                   rd_key <= '0;
        else if (rd_idx > LAST_ROUND) rd_key <= '0;
        else                          rd_key <= rf[rd_idx];
    end
`endif

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Iterative AES-128 key-schedule generator that sits directly upstream of the encrypt round pipeline.
- Accepts a 128-bit cipher key.
- Emits round keys 0..10 in order, one per valid/ready handshake, to feed each round's key input.
- Computes one expansion step per accepted key using 4 S-box lookups. The full 44-word schedule is never held at once, except under the optional feature.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.
- KEY_W, 128, key and round-key width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- start  input  1  request a new expansion; accepted only when ready=1
- key_in  input  128  cipher key, sampled on the start-accept edge; word 0 = key_in[127:96], FIPS-197 byte order
- ready  output  1  high in IDLE only
- rk_valid  output  1  rk_out/rk_index hold a valid round key
- rk_ready  input  1  downstream accepts the current round key
- rk_out  output  128  current round key
- rk_index  output  4  round number of rk_out, 0..10
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; round counter = 0; cur_key = 0.
  - Outputs: rk_valid=0, rk_out=0, rk_index=0, done=0, ready=1 after the edge.
  - Reset overrides everything, including mid-expansion; a partial sequence is abandoned with no done pulse.
- State machine has two states, IDLE and EMIT.
- IDLE:
  - ready=1, rk_valid=0.
  - If start=1: cur_key <= key_in, round <= 0, go to EMIT.
  - Latency: start accepted at edge T; rk_valid=1 with key 0 visible after edge T.
- EMIT:
  - ready=0, rk_valid=1, rk_out=cur_key, rk_index=round.
  - Handshake is rk_valid & rk_ready at a rising edge.
  - Handshake with round<10: cur_key <= next(cur_key, rcon[round+1]); round <= round+1.
  - Handshake with round==10: go to IDLE; done=1 for exactly the next cycle.
  - No handshake: rk_out and rk_index stay stable; rk_valid never drops without a handshake.
- start while not IDLE is ignored; key_in is not resampled.
- start in the same cycle as done=1 (state already IDLE) is accepted normally, giving back-to-back expansions with no idle gap beyond the done cycle.
- Throughput: 11 keys in 11 cycles with rk_ready tied high.
- next(k, rc) (FIPS-197):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rc, 24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - RotWord rotates bytes left by one: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Index 0 is unused.
- The next-key path is combinational from cur_key and registered only on a handshake.

Optional Feature:
Macro ROUND_KEY_STORE_EN.
- Defined:
  - Adds an 11x128 register file, written with rk_out at each handshake, at address rk_index.
  - Adds input rd_idx[3:0] and output rd_key[127:0].
  - rd_key is registered, 1-cycle read latency.
  - rd_idx > 10 returns 0.
  - Contents survive until overwritten; reset clears the whole file to 0.
  - Purpose: reverse-order key supply for a future decrypt path.
- Undefined: no storage and no rd_idx/rd_key ports; behaviour is otherwise identical.

Decomposition:
- Shared package/include aes_pkg:
  - NR and KEY_W constants.
  - Rcon table as a function rcon(idx).
  - State encodings IDLE=1'b0, EMIT=1'b1.
  - The S-box function, shared with the round's subBytes.
- One sub-module, aes_sbox (8-bit in, 8-bit out, combinational), instantiated 4 times for SubWord.

Test Plan:
1. FIPS-197 A.1: start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1.
   - rk_index 0 gives the input key.
   - Index 1 gives a0fafe1788542cb123a339392a6c7605.
   - Index 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done pulses 12 cycles after the start edge.
2. Backpressure: same key, rk_ready low for 3 cycles while rk_index=4. rk_out and rk_index stay stable; the sequence then resumes at index 5 with the correct value.
3. start pulsed during EMIT with a different key_in: ignored; the key-10 output still matches test 1.
4. reset=0 asserted while rk_index=6, then released:
   - All outputs are 0 with ready=1 and no done pulse.
   - A new start with key 000102030405060708090a0b0c0d0e0f yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
5. start asserted in the done cycle: the second expansion begins immediately, with key 0 visible one edge later.
6. With ROUND_KEY_STORE_EN, after test 1:
   - rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later.
   - rd_idx=0 gives the input key.
   - rd_idx=15 gives 0.
